// File: rtl/dmem_sized_wait_pkg.sv
// Shared definitions for the sized data memory: funct3 access codes, FSM states
// and the legality check applied to every request before it may touch storage.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Returns 1 when the access is legal: known size, natural alignment, in range.
  function automatic logic dmem_addr_ok(input logic [2:0]  funct3,
                                        input logic [31:0] addr,
                                        input logic        is_write,
                                        input logic [31:0] depth);
    logic ok;
    ok = 1'b1;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = !addr[0];
      F3_W:    ok = (addr[1:0] == 2'b00);
      F3_BU:   ok = !is_write;
      F3_HU:   ok = !is_write && !addr[0];
      default: ok = 1'b0;
    endcase
    if ({2'b00, addr[31:2]} >= depth) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated write data,
// plus sign/zero extension of the selected load lane. Zero latency, no flow control.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = rdata_raw[{addr_lo, 3'b000} +: 8];
  assign sel_half = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];

  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = wdata;
    rdata_ext   = rdata_raw;
    case (funct3)
      F3_B: begin
        byte_en     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{sel_byte[7]}}, sel_byte};
      end
      F3_H: begin
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{sel_half[15]}}, sel_half};
      end
      F3_W: begin
        byte_en = 4'b1111;
      end
      F3_BU: rdata_ext = {24'd0, sel_byte};
      F3_HU: rdata_ext = {16'd0, sel_half};
      default: begin
        byte_en   = 4'b0000;
        rdata_ext = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_sized_wait.sv
// Word-organised data memory with B/H/W access; response WAIT_CYCLES+1 cycles after accept
// (same-cycle commit when WAIT_CYCLES is 0). req_ready drops during WAIT; no response back-pressure.
module dmem_sized_wait
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam bit DIRECT = (WAIT_CYCLES == 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          hold_write_q, hold_write_d;
  logic [2:0]    hold_funct3_q, hold_funct3_d;
  logic [31:0]   hold_addr_q, hold_addr_d;
  logic [31:0]   hold_wdata_q, hold_wdata_d;

  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  logic [31:0]   storage [DEPTH];

  logic          accept;
  logic          commit;
  logic          c_write;
  logic [2:0]    c_funct3;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic          c_ok;
  logic [AW-1:0] word_idx;
  logic [31:0]   rdata_raw;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_lanes;
  logic [31:0]   rdata_ext;
  logic          mem_we;

  assign req_ready = (state_q == IDLE) || (state_q == RESP);
  assign accept    = req_valid && req_ready;

  // With no wait states the commit lands on the accept edge, so the live request is used.
  assign c_write  = DIRECT ? req_write  : hold_write_q;
  assign c_funct3 = DIRECT ? req_funct3 : hold_funct3_q;
  assign c_addr   = DIRECT ? req_addr   : hold_addr_q;
  assign c_wdata  = DIRECT ? req_wdata  : hold_wdata_q;

  assign commit    = !reset && (DIRECT ? accept : (state_q == WAIT && cnt_q == '0));
  assign c_ok      = dmem_addr_ok(c_funct3, c_addr, c_write, 32'(DEPTH));
  assign word_idx  = c_addr[AW+1:2];
  assign rdata_raw = c_ok ? storage[word_idx] : 32'd0;
  assign mem_we    = commit && c_ok && c_write;

  dmem_lane_align u_lane_align (
    .funct3      (c_funct3),
    .addr_lo     (c_addr[1:0]),
    .wdata       (c_wdata),
    .rdata_raw   (rdata_raw),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_write_d  = hold_write_q;
    hold_funct3_d = hold_funct3_q;
    hold_addr_d   = hold_addr_q;
    hold_wdata_d  = hold_wdata_q;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = 32'd0;
    resp_err_d    = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          hold_write_d  = req_write;
          hold_funct3_d = req_funct3;
          hold_addr_d   = req_addr;
          hold_wdata_d  = req_wdata;
          if (DIRECT) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(WAIT_CYCLES - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      resp_valid_d = 1'b1;
      resp_err_d   = !c_ok;
      resp_rdata_d = (c_ok && !c_write) ? rdata_ext : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hold_write_q  <= 1'b0;
      hold_funct3_q <= 3'd0;
      hold_addr_q   <= 32'd0;
      hold_wdata_q  <= 32'd0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'd0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_write_q  <= hold_write_d;
      hold_funct3_q <= hold_funct3_d;
      hold_addr_q   <= hold_addr_d;
      hold_wdata_q  <= hold_wdata_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
    end
  end

  // Contents are deliberately not reset; commit already excludes reset cycles.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) storage[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_sized_wait.sv
// Two memories (no wait states and three wait states) driven by directed and random
// requests; a byte-array model predicts each response and a monitor checks them in order.
module tb_dmem_sized_wait;
  import dmem_pkg::*;

  localparam int DEPTH = 16;
  localparam int WC0   = 0;
  localparam int WC1   = 3;

  logic              clk = 1'b0;
  logic [1:0]        rst;
  logic [1:0]        req_valid, req_ready, req_write;
  logic [1:0][2:0]   req_funct3;
  logic [1:0][31:0]  req_addr, req_wdata;
  logic [1:0]        resp_valid, resp_err;
  logic [1:0][31:0]  resp_rdata;

  typedef struct {
    int          inst;
    int          due;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  mb [2][DEPTH*4];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_sized_wait #(.DEPTH(DEPTH), .WAIT_CYCLES(g == 0 ? WC0 : WC1)) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_funct3 (req_funct3[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  function automatic int wc(input int i);
    return (i == 0) ? WC0 : WC1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference behaviour: legality from the access rules, then little-endian byte array access.
  task automatic model(input int i, input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int          n;
    logic [31:0] v;
    n  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e  = 1'b0;
    rd = 32'd0;
    if (f3 == 3'd3 || f3 >= 3'd6 || (w && f3 >= 3'd4)) e = 1'b1;
    if (a % n != 0) e = 1'b1;
    if ((a >> 2) >= DEPTH) e = 1'b1;
    if (!e) begin
      if (w) begin
        for (int k = 0; k < n; k++) mb[i][a + k] = wd[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mb[i][a + k];
        if (f3 == F3_B)      rd = {{24{v[7]}}, v[7:0]};
        else if (f3 == F3_H) rd = {{16{v[15]}}, v[15:0]};
        else                 rd = v;
      end
    end
  endtask

  task automatic issue_raw(input int i, input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output int acc);
    int   t;
    logic r;
    t = 0;
    req_valid[i]  = 1'b1;
    req_write[i]  = w;
    req_funct3[i] = f3;
    req_addr[i]   = a;
    req_wdata[i]  = wd;
    do begin
      @(negedge clk);
      r = req_ready[i];
      @(posedge clk);
      t++;
    end while (!r && t < 20);
    #1;
    if (!r) begin
      checks++;
      $display("FAIL accept_timeout inst%0d: req_ready stayed 0 for %0d cycles, expected 1", i, t);
    end
    acc = cyc;
  endtask

  task automatic issue(input int i, input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input string nm);
    int          acc;
    logic [31:0] rd;
    logic        e;
    exp_t        x;
    issue_raw(i, w, f3, a, wd, acc);
    model(i, w, f3, a, wd, rd, e);
    x.inst = i; x.due = acc + wc(i); x.rdata = rd; x.err = e; x.name = nm;
    sbq.push_back(x);
  endtask

  task automatic idle(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_pending", sbq.size(), 0);
  endtask

  task automatic monitor();
    exp_t x;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (resp_valid[i]) begin
          if (sbq.size() == 0 || sbq[0].inst != i) begin
            checks++;
            $display("FAIL unexpected_resp inst%0d: got resp rdata=%h err=%b, expected none", i,
                     resp_rdata[i], resp_err[i]);
          end else begin
            x = sbq.pop_front();
            chk({x.name, "_rdata"}, resp_rdata[i], x.rdata);
            chk({x.name, "_err"}, 32'(resp_err[i]), 32'(x.err));
            chk({x.name, "_cycle"}, cyc, x.due);
          end
        end else begin
          chk("idle_rdata", resp_rdata[i], 32'd0);
          chk("idle_err", 32'(resp_err[i]), 32'd0);
        end
      end
      if (sbq.size() != 0 && cyc > sbq[0].due) begin
        x = sbq.pop_front();
        checks++;
        $display("FAIL missing_resp %s: no resp_valid at cycle %0d, expected one", x.name, x.due);
      end
    end
  endtask

  initial begin
    int          acc;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;

    rst        = 2'b11;
    req_valid  = '0;
    req_write  = '0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", 32'(req_ready[i]), 32'd1);
      chk("reset_resp_valid", 32'(resp_valid[i]), 32'd0);
      chk("reset_rdata", resp_rdata[i], 32'd0);
      chk("reset_err", 32'(resp_err[i]), 32'd0);
    end
    @(posedge clk);
    #1;
    fork
      monitor();
    join_none

    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < DEPTH; k++) issue(i, 1'b1, F3_W, 32'(4*k), $urandom, "prefill_sw");
      idle(i);
      drain();
    end

    issue(0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, "sw_10");
    issue(0, 1'b0, F3_W, 32'h10, 32'h0, "lw_10_b2b");
    issue(0, 1'b1, F3_B, 32'h11, 32'h00000080, "sb_11");
    issue(0, 1'b0, F3_B, 32'h11, 32'h0, "lb_11");
    issue(0, 1'b0, F3_BU, 32'h11, 32'h0, "lbu_11");
    issue(0, 1'b1, F3_H, 32'h12, 32'h00001234, "sh_12");
    issue(0, 1'b0, F3_W, 32'h10, 32'h0, "lw_10_merged");
    issue(0, 1'b0, F3_W, 32'h13, 32'h0, "lw_misaligned");
    issue(0, 1'b1, F3_W, 32'(DEPTH*4), 32'h55AA55AA, "sw_out_of_range");
    issue(0, 1'b0, F3_W, 32'h0, 32'h0, "lw_0_unchanged");
    issue(0, 1'b0, 3'd3, 32'h4, 32'h0, "f3_illegal");
    idle(0);
    drain();

    issue(1, 1'b0, F3_W, 32'h10, 32'h0, "lw_wait3");
    idle(1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wait_ready_low", 32'(req_ready[1]), 32'd0);
    end
    @(negedge clk);
    chk("wait_ready_back", 32'(req_ready[1]), 32'd1);
    chk("wait_resp_valid", 32'(resp_valid[1]), 32'd1);
    @(posedge clk);
    #1;

    issue(1, 1'b1, F3_W, 32'h20, 32'hCAFEF00D, "sw_20_prior");
    idle(1);
    drain();
    issue_raw(1, 1'b1, F3_W, 32'h20, 32'h11111111, acc);
    idle(1);
    @(posedge clk);
    #1 rst[1] = 1'b1;
    @(posedge clk);
    #1 rst[1] = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 32'(req_ready[1]), 32'd1);
    chk("post_reset_resp_valid", 32'(resp_valid[1]), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    issue(1, 1'b0, F3_W, 32'h20, 32'h0, "lw_20_after_reset");
    idle(1);
    drain();

    for (int i = 0; i < 2; i++) begin
      repeat (120) begin
        w  = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH*4 + 7));
        issue(i, w, f3, a, $urandom, w ? "rand_store" : "rand_load");
        if ($urandom_range(0, 3) == 0) begin
          idle(i);
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      idle(i);
      drain();
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_sized_wait.md
# dmem_sized_wait

Parametrised word-organised data memory for the MEM stage of the 5-stage core. Supports RISC-V byte, halfword and word loads and stores, selected by funct3, with sign or zero extension. A valid/ready request channel and a configurable wait-state counter let the pipeline model slow memory by stalling on `req_ready`. Misaligned, out-of-range and illegal-size accesses are detected and reported instead of corrupting storage.

## Interface
- `DEPTH`, 1024: number of 32-bit words; must be at least 1.
- `WAIT_CYCLES`, 0: extra cycles between request acceptance and response; must be at least 0.

- `clk` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request can be accepted this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: access was rejected.

## Operation
- **Accept:** a request is accepted on a rising edge where `req_valid && req_ready`. The request fields are captured into holding registers at that edge.
- **FSM states:** IDLE, WAIT, RESP.
  - `req_ready = (state == IDLE || state == RESP)`.
- **Transitions:**
  - IDLE or RESP, with an accept:
    - if `WAIT_CYCLES == 0`, go to RESP;
    - otherwise go to WAIT and load the counter with `WAIT_CYCLES-1`.
  - IDLE or RESP, with no accept: go to IDLE.
  - WAIT: decrement the counter each cycle. When the counter is 0, go to RESP.
- **Commit:** happens on the edge that enters RESP. Stores write the memory; loads sample the memory. `resp_*` registers are loaded on this same edge, so `resp_valid = 1` exactly during the RESP cycle.
- **Errors:** an access is an error, with no write and `resp_rdata = 0`, if any of these hold:
  - funct3 is 3, 6 or 7;
  - it is a store with funct3 4 or 5;
  - it is misaligned: H/HU with `addr[0] != 0`, or W with `addr[1:0] != 0`;
  - it is out of range: `addr[31:2] >= DEPTH`.
- **Byte lanes for stores:**
  - SB writes lane `addr[1:0]` with `wdata[7:0]`.
  - SH writes lanes {`addr[1]`*2+1, `addr[1]`*2} with `wdata[15:0]`.
  - SW writes all four lanes.
  - Unselected lanes are unchanged.
- **Load extension:**
  - LB/LH sign-extend the selected byte or halfword.
  - LBU/LHU zero-extend it.
  - LW returns the whole word.
- **Reset:** memory contents are not reset and are undefined until written. A request pending in WAIT is dropped and performs no write.

## Timing
- **Reset values:** `state = IDLE`, counter 0, `resp_valid = 0`, `resp_rdata = 0`, `resp_err = 0`. `req_ready = 1` in the first cycle after reset.
- **Latency:** `resp_valid` asserts `WAIT_CYCLES+1` cycles after the acceptance edge.
- **Throughput:**
  - `WAIT_CYCLES = 0`: one request per cycle, back to back.
  - Otherwise: one request per `WAIT_CYCLES+1` cycles, since `req_ready` is low throughout WAIT.
- **Ordering:** commits happen in acceptance order. A load accepted in the RESP cycle of a store observes that store's data.
- **Outputs:**
  - `resp_rdata` and `resp_err` are valid only while `resp_valid = 1`.
  - Outside RESP they hold 0, cleared on the edge that leaves RESP.
- **No response back-pressure:** the consumer must take the response in the RESP cycle.
- **Reset priority:** `reset` asserted in the same cycle as an accept wins. There is no accept and no commit.

## Structure
- **Package `dmem_pkg`:**
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - state enum {IDLE, WAIT, RESP};
  - function `dmem_addr_ok(funct3, addr, is_write, depth)` returning the error check.
- **Sub-module `dmem_lane_align`:** combinational. It produces the 4-bit byte-enable mask and the lane-replicated write data from funct3, `addr[1:0]` and wdata. It also produces the extended load data from the raw word.
- **Top level:** holds the FSM, the wait counter, the holding registers and the storage. Storage is an array of `DEPTH` x 32-bit words with per-byte write enables.

## Test plan
- Reset, then check outputs: `req_ready = 1`, `resp_valid = 0`, `resp_rdata = 0`, `resp_err = 0`.
- `WAIT_CYCLES = 0`: SW 0xDEADBEEF to 0x10, then LW 0x10 back to back. Expect two `resp_valid` pulses on consecutive cycles; the second carries `rdata = 0xDEADBEEF`, `err = 0`.
- Byte and half lanes:
  - SB 0x80 to 0x11, then LB 0x11 returns 0xFFFFFF80 and LBU 0x11 returns 0x00000080.
  - SH 0x1234 to 0x12, then LW 0x10 returns 0x123480EF.
- `WAIT_CYCLES = 3`: accept LW. `req_ready` is low for 3 cycles and `resp_valid` rises 4 cycles after the accept edge.
- Errors:
  - LW 0x13 (misaligned) returns `err = 1`, `rdata = 0`.
  - SW to `DEPTH*4` returns `err = 1`, and a later LW of word 0 is unchanged.
  - funct3 = 3 returns `err = 1`.
- `WAIT_CYCLES = 3`: assert `reset` during WAIT of an SW to 0x20. Expect no `resp_valid`, and a subsequent LW 0x20 returns the prior value.
